fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC register and drives the instruction-memory request. It also writes the IF/ID pipeline register. It consumes the already-resolved next-PC and redirect indication from the decode-stage branch logic, and the stall from the hazard unit. It handles instruction-memory misses, squashes the wrong-path fetch on redirect, and freezes fetch after a HLT instruction.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 63 ++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: next-PC/redirect/stall in, instruction-memory request/response, IF/ID out.
// master = fetch_unit side (drives imem request and IF/ID), slave = surrounding pipeline/memory.
// Signals: pcNext, redirect, stall, imemAddr, imemReq, imemData, imemValid,
//          ifidInstr, ifidPc, ifidPcInc, ifidValid, halted.
interface fetch_unit_if;
  logic [15:0] pcNext;
  logic        redirect;
  logic        stall;
  logic [15:0] imemAddr;
  logic        imemReq;
  logic [15:0] imemData;
  logic        imemValid;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPc;
  logic [15:0] ifidPcInc;
  logic        ifidValid;
  logic        halted;

  modport master (
    input  pcNext, redirect, stall, imemData, imemValid,
    output imemAddr, imemReq, ifidInstr, ifidPc, ifidPcInc, ifidValid, halted
  );

  modport slave (
    output pcNext, redirect, stall, imemData, imemValid,
    input  imemAddr, imemReq, ifidInstr, ifidPc, ifidPcInc, ifidValid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, requests instruction memory, writes IF/ID register.
// Latency: instruction sampled at edge N is visible on IF/ID after edge N; redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; a miss (imemValid=0) inserts bubbles while PC holds.
// Ports: clk, rst (async active-high), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_inc;
  logic        ifid_valid;
  logic        halted_q;

  assign pc_inc = pc + 16'd2;  // wraps modulo 2^16

  assign bus.imemAddr  = pc;
  assign bus.imemReq   = ~rst & ~halted_q;
  assign bus.ifidInstr = ifid_instr;
  assign bus.ifidPc    = ifid_pc;
  assign bus.ifidPcInc = ifid_pc_inc;
  assign bus.ifidValid = ifid_valid;
  assign bus.halted    = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      ifid_instr  <= 16'h0000;
      ifid_pc     <= 16'h0000;
      ifid_pc_inc <= 16'h0000;
      ifid_valid  <= 1'b0;
      halted_q    <= 1'b0;
    end else if (bus.stall) begin
      // Hazard unit holds the branch in ID; redirect is re-presented once the stall lifts.
    end else if (bus.redirect) begin
      // Wrong-path word (even a HLT or a hit) is dropped; ifid_pc/ifid_pc_inc keep old values.
      pc         <= {bus.pcNext[15:1], 1'b0};
      ifid_instr <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (halted_q || !bus.imemValid) begin
      ifid_instr <= 16'h0000;
      ifid_valid <= 1'b0;
    end else begin
      pc          <= pc_inc;
      ifid_instr  <= bus.imemData;
      ifid_pc     <= pc;
      ifid_pc_inc <= pc_inc;
      ifid_valid  <= 1'b1;
      // HLT itself is delivered to decode; fetch freezes from the next cycle on.
      if (bus.imemData[15:12] == HALT_OPCODE) begin
        halted_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a per-cycle reference model and literal spot checks.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_ipc, m_iinc;
  logic        m_valid, m_halted;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_iinc = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock: drive inputs at negedge, let the edge happen, then advance the model.
  task automatic step(input logic s, input logic r, input logic [15:0] pn,
                      input logic v, input logic [15:0] d);
    int nxt;
    @(negedge clk);
    bus.stall = s; bus.redirect = r; bus.pcNext = pn; bus.imemValid = v; bus.imemData = d;
    @(posedge clk);
    #1;
    if (s) begin
      // everything frozen
    end else if (r) begin
      m_pc = pn & 16'hFFFE;
      m_valid = 1'b0; m_instr = 16'h0000;
    end else if (m_halted || !v) begin
      m_valid = 1'b0; m_instr = 16'h0000;
    end else begin
      nxt = (int'(m_pc) + 2) % 65536;
      m_instr = d; m_ipc = m_pc; m_iinc = 16'(nxt); m_valid = 1'b1;
      m_pc = 16'(nxt);
      if (d[15:12] == 4'hF) m_halted = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imemAddr"},  bus.imemAddr, 16'h0000);
    chk({tag, "_imemReq"},   {15'd0, bus.imemReq}, 16'h0000);
    chk({tag, "_ifidInstr"}, bus.ifidInstr, 16'h0000);
    chk({tag, "_ifidPc"},    bus.ifidPc, 16'h0000);
    chk({tag, "_ifidPcInc"}, bus.ifidPcInc, 16'h0000);
    chk({tag, "_ifidValid"}, {15'd0, bus.ifidValid}, 16'h0000);
    chk({tag, "_halted"},    {15'd0, bus.halted}, 16'h0000);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc_imemAddr",  bus.imemAddr, m_pc);
      chk("cyc_imemReq",   {15'd0, bus.imemReq}, {15'd0, ~m_halted});
      chk("cyc_ifidInstr", bus.ifidInstr, m_instr);
      chk("cyc_ifidPc",    bus.ifidPc, m_ipc);
      chk("cyc_ifidPcInc", bus.ifidPcInc, m_iinc);
      chk("cyc_ifidValid", {15'd0, bus.ifidValid}, {15'd0, m_valid});
      chk("cyc_halted",    {15'd0, bus.halted}, {15'd0, m_halted});
    end
  end

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.pcNext = 16'h0000;
    bus.imemValid = 1'b0; bus.imemData = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // sequential fetch
    step(0, 0, 16'h0000, 1, 16'h1001);
    chk("seq0_instr", bus.ifidInstr, 16'h1001);
    chk("seq0_pc",    bus.ifidPc,    16'h0000);
    chk("seq0_inc",   bus.ifidPcInc, 16'h0002);
    chk("seq0_valid", {15'd0, bus.ifidValid}, 16'h0001);
    step(0, 0, 16'h0000, 1, 16'h1002);
    chk("seq1_instr", bus.ifidInstr, 16'h1002);
    step(0, 0, 16'h0000, 1, 16'h1003);
    chk("seq2_pc",    bus.ifidPc,    16'h0004);
    chk("seq2_inc",   bus.ifidPcInc, 16'h0006);

    // redirect with odd target, one bubble, then target in IF/ID
    step(0, 1, 16'h0010, 1, 16'h2222);
    step(0, 1, 16'h0041, 1, 16'h2223);
    chk("redir_addr",  bus.imemAddr, 16'h0040);
    chk("redir_valid", {15'd0, bus.ifidValid}, 16'h0000);
    chk("redir_pchold", bus.ifidPc, 16'h0004);
    step(0, 0, 16'h0000, 1, 16'h3040);
    chk("redir_tgt_pc",    bus.ifidPc,    16'h0040);
    chk("redir_tgt_instr", bus.ifidInstr, 16'h3040);

    // stall beats redirect
    step(0, 1, 16'h0006, 1, 16'h0000);
    step(0, 0, 16'h0000, 1, 16'h1006);
    step(1, 1, 16'h0100, 1, 16'h5555);
    step(1, 1, 16'h0100, 1, 16'h5555);
    chk("stall_addr",  bus.imemAddr, 16'h0008);
    chk("stall_instr", bus.ifidInstr, 16'h1006);
    chk("stall_valid", {15'd0, bus.ifidValid}, 16'h0001);
    step(0, 1, 16'h0100, 1, 16'h5555);
    chk("stall_release_addr", bus.imemAddr, 16'h0100);

    // three-cycle miss
    step(0, 1, 16'h0020, 1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'h0000, 0, 16'hDEAD);
      chk("miss_valid", {15'd0, bus.ifidValid}, 16'h0000);
      chk("miss_addr",  bus.imemAddr, 16'h0020);
    end
    step(0, 0, 16'h0000, 1, 16'h4020);
    chk("miss_done_pc",   bus.ifidPc,   16'h0020);
    chk("miss_done_addr", bus.imemAddr, 16'h0022);

    // HLT on the wrong path is ignored, then a real HLT
    step(0, 1, 16'h0006, 1, 16'hF000);
    chk("hlt_squash", {15'd0, bus.halted}, 16'h0000);
    step(0, 0, 16'h0000, 1, 16'hF000);
    chk("hlt_halted", {15'd0, bus.halted}, 16'h0001);
    chk("hlt_req",    {15'd0, bus.imemReq}, 16'h0000);
    chk("hlt_addr",   bus.imemAddr, 16'h0008);
    chk("hlt_instr",  bus.ifidInstr, 16'hF000);
    step(0, 0, 16'h0000, 1, 16'h1234);
    step(0, 0, 16'h0000, 1, 16'h1234);
    chk("hlt_frozen_addr",  bus.imemAddr, 16'h0008);
    chk("hlt_frozen_valid", {15'd0, bus.ifidValid}, 16'h0000);
    step(0, 1, 16'h0030, 1, 16'h1111);
    step(0, 0, 16'h0000, 1, 16'h1111);
    chk("hlt_redir_addr",  bus.imemAddr, 16'h0030);
    chk("hlt_redir_valid", {15'd0, bus.ifidValid}, 16'h0000);

    // reset to leave HALT, then wrap at 16'hFFFE
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    step(0, 1, 16'hFFFF, 1, 16'h0000);
    step(0, 0, 16'h0000, 1, 16'h7777);
    chk("wrap_addr", bus.imemAddr,  16'h0000);
    chk("wrap_pc",   bus.ifidPc,    16'hFFFE);
    chk("wrap_inc",  bus.ifidPcInc, 16'h0000);
    step(0, 0, 16'h0000, 1, 16'h7778);

    // async reset in the middle of a miss
    step(0, 0, 16'h0000, 0, 16'hDEAD);
    chk("pre_rst_addr", bus.imemAddr, 16'h0002);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    step(0, 0, 16'h0000, 1, 16'h1001);
    chk("post_rst_pc", bus.ifidPc, 16'h0000);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
